// File: rtl/asrv32_ctrl_fsm_pkg.sv
// Shared definitions for the asrv32 multi-cycle control path:
// stage encodings and one-hot opcode bit positions from the decoder.
package asrv32_ctrl_fsm_pkg;

  localparam int OPCODE_WIDTH_DEF = 11;

  typedef enum int {
    OP_RTYPE  = 0,
    OP_ITYPE  = 1,
    OP_LOAD   = 2,
    OP_STORE  = 3,
    OP_BRANCH = 4,
    OP_JAL    = 5,
    OP_JALR   = 6,
    OP_LUI    = 7,
    OP_AUIPC  = 8,
    OP_SYSTEM = 9,
    OP_FENCE  = 10
  } opcode_idx_e;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMACCESS = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } stage_e;

endpackage

// File: rtl/asrv32_retire_cnt.sv
// Free-running retired-instruction counter with increment enable;
// wraps modulo 2^W. Shared with the CSR block.
module asrv32_retire_cnt #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/asrv32_ctrl_fsm.sv
// Multi-cycle control FSM for the unpipelined asrv32 core: sequences
// FETCH/DECODE/EXECUTE/MEMACCESS/WRITEBACK with wait states, stall, trap and bus timeout.
module asrv32_ctrl_fsm
  import asrv32_ctrl_fsm_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter int SKIP_MEM     = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int RETIRE_W     = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [31:0]             i_inst,
  input  logic                    i_inst_vld,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_dmem_ack,
  input  logic                    i_stall,
  input  logic                    i_trap,
  output logic [31:0]             o_inst_q,
  output logic [2:0]              o_stage_q,
  output logic                    o_fetch_req,
  output logic                    o_alu_stage_en,
  output logic                    o_memaccess_stage_en,
  output logic                    o_writeback_stage_en,
  output logic                    o_csr_stage_en,
  output logic                    o_flush,
  output logic                    o_bus_err,
  output logic                    o_done_tick,
  output logic [RETIRE_W-1:0]     o_minstret
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  stage_e           stage_q, stage_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             is_ls, is_sys, mem_path;
  logic             unused_opcode;

  assign is_ls    = i_opcode[OP_LOAD] | i_opcode[OP_STORE];
  assign is_sys   = i_opcode[OP_SYSTEM];
  assign mem_path = is_ls || is_sys || (SKIP_MEM == 0);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  // Remaining decoder bits do not steer the sequencing.
  assign unused_opcode = ^i_opcode;

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    stage_d              = stage_q;
    inst_d               = inst_q;
    cnt_d                = cnt_q;
    o_fetch_req          = 1'b0;
    o_alu_stage_en       = 1'b0;
    o_memaccess_stage_en = 1'b0;
    o_writeback_stage_en = 1'b0;
    o_csr_stage_en       = 1'b0;
    o_flush              = 1'b0;
    o_bus_err            = 1'b0;
    o_done_tick          = 1'b0;

    case (stage_q)
      FETCH: begin
        o_fetch_req = !i_stall && !i_rst;
        if (!i_stall && i_inst_vld) begin
          inst_d  = i_inst;
          stage_d = DECODE;
        end
      end
      DECODE: begin
        if (!i_stall) stage_d = EXECUTE;
      end
      EXECUTE: begin
        o_alu_stage_en = !i_stall;
        if (i_trap)        stage_d = TRAP;
        else if (!i_stall) stage_d = mem_path ? MEMACCESS : WRITEBACK;
      end
      MEMACCESS: begin
        o_memaccess_stage_en = !i_stall;
        o_csr_stage_en       = is_sys && !i_stall;
        if (i_trap) begin
          stage_d = TRAP;
          cnt_d   = '0;
        end else if (!i_stall) begin
          if (!is_ls || i_dmem_ack) begin
            stage_d = WRITEBACK;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_W'(MEM_TIMEOUT)) begin
            // Ack arriving on the final allowed cycle takes the branch above.
            o_bus_err = 1'b1;
            stage_d   = TRAP;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      WRITEBACK: begin
        o_writeback_stage_en = !i_stall;
        o_done_tick          = !i_stall;
        if (!i_stall) stage_d = FETCH;
      end
      TRAP: begin
        o_flush = 1'b1;
        if (!i_stall) stage_d = FETCH;
      end
      default: stage_d = FETCH;
    endcase
  end

  // NOTE: non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stage_q <= FETCH;
      inst_q  <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_inst_q  = inst_q;
  assign o_stage_q = stage_q;

  asrv32_retire_cnt #(.W(RETIRE_W)) u_retire_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (o_done_tick),
    .o_cnt (o_minstret)
  );

endmodule

// File: tb/tb_asrv32_ctrl_fsm.sv
// Directed bench for asrv32_ctrl_fsm: expectations queued per cycle as stimulus is
// applied, compared against the DUT outputs on the falling edge.
module tb_asrv32_ctrl_fsm;
  import asrv32_ctrl_fsm_pkg::*;

  localparam logic [7:0] F_FETCH = 8'b1000_0000;
  localparam logic [7:0] F_ALU   = 8'b0100_0000;
  localparam logic [7:0] F_MEM   = 8'b0010_0000;
  localparam logic [7:0] F_WB    = 8'b0001_0000;
  localparam logic [7:0] F_CSR   = 8'b0000_1000;
  localparam logic [7:0] F_FLUSH = 8'b0000_0100;
  localparam logic [7:0] F_BERR  = 8'b0000_0010;
  localparam logic [7:0] F_DONE  = 8'b0000_0001;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;
  localparam logic [31:0] I_LW    = 32'h0000_a103;
  localparam logic [31:0] I_SW    = 32'h0020_a023;
  localparam logic [31:0] I_ECALL = 32'h0000_0073;

  typedef struct {
    int          sel;
    string       tag;
    logic [2:0]  stage;
    logic [7:0]  flags;
    logic [31:0] inst;
    logic [63:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: SKIP_MEM=1, MEM_TIMEOUT=15, RETIRE_W=64
  logic        rst, inst_vld, dmem_ack, stall, trap;
  logic [31:0] inst;
  logic [10:0] opcode;
  logic [31:0] inst_q;
  logic [2:0]  stage_q;
  logic        fetch_req, alu_en, mem_en, wb_en, csr_en, flush, bus_err, done_tick;
  logic [63:0] minstret;

  // Second instance: SKIP_MEM=0, RETIRE_W=4
  logic        rst2, inst_vld2, dmem_ack2, stall2, trap2;
  logic [31:0] inst2;
  logic [10:0] opcode2;
  logic [31:0] inst_q2;
  logic [2:0]  stage_q2;
  logic        fetch_req2, alu_en2, mem_en2, wb_en2, csr_en2, flush2, bus_err2, done_tick2;
  logic [3:0]  minstret2;

  asrv32_ctrl_fsm #(.OPCODE_WIDTH(11), .SKIP_MEM(1), .MEM_TIMEOUT(15), .RETIRE_W(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_inst(inst), .i_inst_vld(inst_vld), .i_opcode(opcode),
    .i_dmem_ack(dmem_ack), .i_stall(stall), .i_trap(trap),
    .o_inst_q(inst_q), .o_stage_q(stage_q), .o_fetch_req(fetch_req),
    .o_alu_stage_en(alu_en), .o_memaccess_stage_en(mem_en), .o_writeback_stage_en(wb_en),
    .o_csr_stage_en(csr_en), .o_flush(flush), .o_bus_err(bus_err),
    .o_done_tick(done_tick), .o_minstret(minstret)
  );

  asrv32_ctrl_fsm #(.OPCODE_WIDTH(11), .SKIP_MEM(0), .MEM_TIMEOUT(15), .RETIRE_W(4)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_inst(inst2), .i_inst_vld(inst_vld2), .i_opcode(opcode2),
    .i_dmem_ack(dmem_ack2), .i_stall(stall2), .i_trap(trap2),
    .o_inst_q(inst_q2), .o_stage_q(stage_q2), .o_fetch_req(fetch_req2),
    .o_alu_stage_en(alu_en2), .o_memaccess_stage_en(mem_en2), .o_writeback_stage_en(wb_en2),
    .o_csr_stage_en(csr_en2), .o_flush(flush2), .o_bus_err(bus_err2),
    .o_done_tick(done_tick2), .o_minstret(minstret2)
  );

  logic [31:0] exp_inst  = '0;
  logic [63:0] exp_cnt   = '0;
  logic [31:0] exp_inst2 = '0;
  logic [63:0] exp_cnt2  = '0;

  // Queue the expectation for the cycle whose inputs were just driven, then advance.
  task automatic cyc(input int sel, input string tag, input logic [2:0] st, input logic [7:0] fl);
    exp_t e;
    e.sel   = sel;
    e.tag   = tag;
    e.stage = st;
    e.flags = fl;
    e.inst  = (sel == 0) ? exp_inst : exp_inst2;
    e.cnt   = (sel == 0) ? exp_cnt  : exp_cnt2;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  exp_t        m_e;
  logic [2:0]  obs_stage;
  logic [7:0]  obs_flags;
  logic [31:0] obs_inst;
  logic [63:0] obs_cnt;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      if (m_e.sel == 0) begin
        obs_stage = stage_q;
        obs_flags = {fetch_req, alu_en, mem_en, wb_en, csr_en, flush, bus_err, done_tick};
        obs_inst  = inst_q;
        obs_cnt   = minstret;
      end else begin
        obs_stage = stage_q2;
        obs_flags = {fetch_req2, alu_en2, mem_en2, wb_en2, csr_en2, flush2, bus_err2, done_tick2};
        obs_inst  = inst_q2;
        obs_cnt   = {60'd0, minstret2};
      end
      compared++;
      assert (obs_stage === m_e.stage) else begin
        mismatched++;
        $error("FAIL %s.stage observed %0d expected %0d", m_e.tag, obs_stage, m_e.stage);
      end
      compared++;
      assert (obs_flags === m_e.flags) else begin
        mismatched++;
        $error("FAIL %s.flags observed %b expected %b", m_e.tag, obs_flags, m_e.flags);
      end
      compared++;
      assert (obs_inst === m_e.inst) else begin
        mismatched++;
        $error("FAIL %s.inst observed %h expected %h", m_e.tag, obs_inst, m_e.inst);
      end
      compared++;
      assert (obs_cnt === m_e.cnt) else begin
        mismatched++;
        $error("FAIL %s.minstret observed %0d expected %0d", m_e.tag, obs_cnt, m_e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; inst = '0; inst_vld = 1'b0; opcode = '0; dmem_ack = 1'b0; stall = 1'b0; trap = 1'b0;
    rst2 = 1'b1; inst2 = I_ADDI; inst_vld2 = 1'b1; opcode2 = 11'd1 << OP_ITYPE;
    dmem_ack2 = 1'b0; stall2 = 1'b0; trap2 = 1'b0;

    @(posedge clk); #1;
    cyc(0, "reset", FETCH, 8'h00);
    rst = 1'b0;

    // ADDI with SKIP_MEM=1: 0,1,2,4 then back to FETCH
    inst = I_ADDI; inst_vld = 1'b1; opcode = 11'd1 << OP_ITYPE;
    cyc(0, "addi_f", FETCH, F_FETCH);
    exp_inst = I_ADDI; inst_vld = 1'b0;
    cyc(0, "addi_d", DECODE, 8'h00);
    cyc(0, "addi_e", EXECUTE, F_ALU);
    cyc(0, "addi_wb", WRITEBACK, F_WB | F_DONE);
    exp_cnt = 1;
    cyc(0, "fetch_idle", FETCH, F_FETCH);

    // LW: stall in FETCH holds, then ack on 3rd MEMACCESS cycle
    inst = I_LW; inst_vld = 1'b1; opcode = 11'd1 << OP_LOAD; stall = 1'b1;
    cyc(0, "lw_f_stall", FETCH, 8'h00);
    stall = 1'b0;
    cyc(0, "lw_f", FETCH, F_FETCH);
    exp_inst = I_LW; inst_vld = 1'b0;
    cyc(0, "lw_d", DECODE, 8'h00);
    cyc(0, "lw_e", EXECUTE, F_ALU);
    cyc(0, "lw_m1", MEMACCESS, F_MEM);
    cyc(0, "lw_m2", MEMACCESS, F_MEM);
    dmem_ack = 1'b1;
    cyc(0, "lw_m3", MEMACCESS, F_MEM);
    dmem_ack = 1'b0;
    cyc(0, "lw_wb", WRITEBACK, F_WB | F_DONE);
    exp_cnt = 2;

    // SW with no ack: bus error on the 15th wait cycle, then TRAP
    inst = I_SW; inst_vld = 1'b1; opcode = 11'd1 << OP_STORE;
    cyc(0, "sw_f", FETCH, F_FETCH);
    exp_inst = I_SW; inst_vld = 1'b0;
    cyc(0, "sw_d", DECODE, 8'h00);
    cyc(0, "sw_e", EXECUTE, F_ALU);
    for (int i = 0; i < 14; i++) cyc(0, "sw_wait", MEMACCESS, F_MEM);
    cyc(0, "sw_timeout", MEMACCESS, F_MEM | F_BERR);
    cyc(0, "sw_trap", TRAP, F_FLUSH);

    // SW with ack exactly on the 15th cycle: ack wins
    inst = I_SW; inst_vld = 1'b1;
    cyc(0, "sw2_f", FETCH, F_FETCH);
    inst_vld = 1'b0;
    cyc(0, "sw2_d", DECODE, 8'h00);
    cyc(0, "sw2_e", EXECUTE, F_ALU);
    for (int i = 0; i < 14; i++) cyc(0, "sw2_wait", MEMACCESS, F_MEM);
    dmem_ack = 1'b1;
    cyc(0, "sw2_ack_edge", MEMACCESS, F_MEM);
    dmem_ack = 1'b0;
    cyc(0, "sw2_wb", WRITEBACK, F_WB | F_DONE);
    exp_cnt = 3;

    // ECALL: CSR enable in MEMACCESS; trap in DECODE is ignored
    inst = I_ECALL; inst_vld = 1'b1; opcode = 11'd1 << OP_SYSTEM;
    cyc(0, "ecall_f", FETCH, F_FETCH);
    exp_inst = I_ECALL; inst_vld = 1'b0; trap = 1'b1;
    cyc(0, "ecall_d_trap", DECODE, 8'h00);
    trap = 1'b0;
    cyc(0, "ecall_e", EXECUTE, F_ALU);
    cyc(0, "ecall_m", MEMACCESS, F_MEM | F_CSR);
    cyc(0, "ecall_wb", WRITEBACK, F_WB | F_DONE);
    exp_cnt = 4;

    // ADDI stalled 3 cycles in EXECUTE, then 1 cycle in WRITEBACK
    inst = I_ADDI; inst_vld = 1'b1; opcode = 11'd1 << OP_ITYPE;
    cyc(0, "stl_f", FETCH, F_FETCH);
    exp_inst = I_ADDI; inst_vld = 1'b0;
    cyc(0, "stl_d", DECODE, 8'h00);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, "stl_e_hold", EXECUTE, 8'h00);
    stall = 1'b0;
    cyc(0, "stl_e", EXECUTE, F_ALU);
    stall = 1'b1;
    cyc(0, "stl_wb_hold", WRITEBACK, 8'h00);
    stall = 1'b0;
    cyc(0, "stl_wb", WRITEBACK, F_WB | F_DONE);
    exp_cnt = 5;

    // Trap beats stall in EXECUTE
    inst_vld = 1'b1;
    cyc(0, "tst_f", FETCH, F_FETCH);
    inst_vld = 1'b0;
    cyc(0, "tst_d", DECODE, 8'h00);
    stall = 1'b1; trap = 1'b1;
    cyc(0, "tst_e", EXECUTE, 8'h00);
    stall = 1'b0; trap = 1'b0;
    cyc(0, "tst_trap", TRAP, F_FLUSH);

    // Trap beats ack in MEMACCESS
    inst = I_LW; inst_vld = 1'b1; opcode = 11'd1 << OP_LOAD;
    cyc(0, "tmem_f", FETCH, F_FETCH);
    exp_inst = I_LW; inst_vld = 1'b0;
    cyc(0, "tmem_d", DECODE, 8'h00);
    cyc(0, "tmem_e", EXECUTE, F_ALU);
    trap = 1'b1; dmem_ack = 1'b1;
    cyc(0, "tmem_m", MEMACCESS, F_MEM);
    trap = 1'b0; dmem_ack = 1'b0;
    cyc(0, "tmem_trap", TRAP, F_FLUSH);

    // Reset asserted during MEMACCESS abandons the instruction
    inst = I_SW; inst_vld = 1'b1; opcode = 11'd1 << OP_STORE;
    cyc(0, "rmem_f", FETCH, F_FETCH);
    exp_inst = I_SW; inst_vld = 1'b0;
    cyc(0, "rmem_d", DECODE, 8'h00);
    cyc(0, "rmem_e", EXECUTE, F_ALU);
    cyc(0, "rmem_m", MEMACCESS, F_MEM);
    rst = 1'b1; exp_inst = '0; exp_cnt = '0;
    cyc(0, "rmem_rst", FETCH, 8'h00);
    rst = 1'b0;
    cyc(0, "rmem_after", FETCH, F_FETCH);

    // SKIP_MEM=0, RETIRE_W=4: ADDI visits MEMACCESS; 17 retires wrap to 1
    rst2 = 1'b0;
    for (int n = 0; n < 17; n++) begin
      cyc(1, "w_f", FETCH, F_FETCH);
      exp_inst2 = I_ADDI;
      cyc(1, "w_d", DECODE, 8'h00);
      cyc(1, "w_e", EXECUTE, F_ALU);
      cyc(1, "w_m", MEMACCESS, F_MEM);
      cyc(1, "w_wb", WRITEBACK, F_WB | F_DONE);
      exp_cnt2 = (exp_cnt2 + 64'd1) & 64'hF;
    end
    cyc(1, "w_wrapped", FETCH, F_FETCH);

    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("FAIL drain observed %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
